// File: rtl/ysyx_22040759_core_seq.sv
// Multi-cycle instruction sequencer for the RV64 core.
// Owns the PC and fetches over a request/grant/rvalid handshake. Walks each
// instruction through EXEC, MEM and WB, and gates the decoder's raw write
// enables so that every instruction commits exactly once. Halts on ebreak,
// and traps to HALT with err_o on an illegal instruction or a memory timeout.
module ysyx_22040759_core_seq #(
   parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
   parameter int unsigned TMO_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [63:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] inst_o,
   output logic [63:0] pc_o,
   input  logic        dec_reg_wen_i,
   input  logic        dec_mem_wen_i,
   input  logic        dec_mem_ren_i,
   input  logic        dec_pc_sel_i,
   input  logic        dec_illegal_i,
   input  logic        dec_ebreak_i,
   input  logic [63:0] alu_res_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   output logic        rf_wen_o,
   output logic        commit_o,
   output logic        halt_o,
   output logic        err_o
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_IWAIT,
      S_EXEC,
      S_MEM,
      S_MWAIT,
      S_WB,
      S_HALT
   } state_e;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   // Last count value before the wait is declared timed out.
   localparam logic [7:0]  TMO_LAST = 8'(TMO_CYCLES - 1);

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        halt_q, halt_d;
   logic        err_q, err_d;

   logic        imem_req;
   logic        dmem_req;
   logic        dmem_we;
   logic        rf_wen;
   logic        commit;
   logic        wait_tick;

   // Next-state, PC/instruction update, timeout and handshake outputs.
   always_comb begin
      // NOTE: every variable gets a default first so no path through the case infers a latch.
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      cnt_d     = cnt_q;
      halt_d    = halt_q;
      err_d     = err_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      rf_wen    = 1'b0;
      commit    = 1'b0;
      wait_tick = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_gnt_i) begin
               // A response arriving with the grant skips the IWAIT cycle.
               if (imem_rvalid_i) begin
                  inst_d  = imem_rdata_i;
                  state_d = S_EXEC;
               end else begin
                  state_d = S_IWAIT;
               end
            end else begin
               wait_tick = 1'b1;
            end
         end
         S_IWAIT: begin
            if (imem_rvalid_i) begin
               inst_d  = imem_rdata_i;
               state_d = S_EXEC;
            end else begin
               wait_tick = 1'b1;
            end
         end
         S_EXEC: begin
            // Illegal wins over ebreak; neither instruction ever commits.
            if (dec_illegal_i) begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end else if (dec_ebreak_i) begin
               halt_d  = 1'b1;
               state_d = S_HALT;
            end else if (dec_mem_ren_i || dec_mem_wen_i) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = dec_mem_wen_i;
            if (dmem_gnt_i) begin
               if (dec_mem_wen_i || dmem_rvalid_i) state_d = S_WB;
               else                                state_d = S_MWAIT;
            end else begin
               wait_tick = 1'b1;
            end
         end
         S_MWAIT: begin
            if (dmem_rvalid_i) state_d = S_WB;
            else               wait_tick = 1'b1;
         end
         S_WB: begin
            rf_wen  = dec_reg_wen_i;
            commit  = 1'b1;
            pc_d    = dec_pc_sel_i ? (alu_res_i & ~64'h1) : (pc_q + 64'd4);
            state_d = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // One more idle cycle in a waiting state either counts or trips the timeout.
      if (wait_tick) begin
         if (cnt_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_HALT;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end

      if (state_d != state_q) cnt_d = '0;
   end

   // State, PC, instruction latch, timeout counter and sticky flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         inst_q  <= NOP_INST;
         cnt_q   <= '0;
         halt_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         cnt_q   <= cnt_d;
         halt_q  <= halt_d;
         err_q   <= err_d;
      end
   end

   // Requests are held low while reset is asserted, even though the state is FETCH.
   assign imem_req_o  = imem_req & ~rst;
   assign dmem_req_o  = dmem_req & ~rst;
   assign dmem_we_o   = dmem_we  & ~rst;
   assign rf_wen_o    = rf_wen   & ~rst;
   assign commit_o    = commit   & ~rst;
   assign imem_addr_o = pc_q;
   assign pc_o        = pc_q;
   assign inst_o      = inst_q;
   assign halt_o      = halt_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_ysyx_22040759_core_seq.sv
// Self-checking bench for ysyx_22040759_core_seq: schedule-based reference
// model of each instruction's phases, randomized memory delays, and directed
// reset, trap, wrap-around and timeout scenarios.
module tb_ysyx_22040759_core_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_o;
   logic [63:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] inst_o;
   logic [63:0] pc_o;
   logic        dec_reg_wen_i;
   logic        dec_mem_wen_i;
   logic        dec_mem_ren_i;
   logic        dec_pc_sel_i;
   logic        dec_illegal_i;
   logic        dec_ebreak_i;
   logic [63:0] alu_res_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic        rf_wen_o;
   logic        commit_o;
   logic        halt_o;
   logic        err_o;

   ysyx_22040759_core_seq dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_gnt_i   (imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i (imem_rdata_i),
      .inst_o       (inst_o),
      .pc_o         (pc_o),
      .dec_reg_wen_i(dec_reg_wen_i),
      .dec_mem_wen_i(dec_mem_wen_i),
      .dec_mem_ren_i(dec_mem_ren_i),
      .dec_pc_sel_i (dec_pc_sel_i),
      .dec_illegal_i(dec_illegal_i),
      .dec_ebreak_i (dec_ebreak_i),
      .alu_res_i    (alu_res_i),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_gnt_i   (dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i),
      .rf_wen_o     (rf_wen_o),
      .commit_o     (commit_o),
      .halt_o       (halt_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   logic [63:0] cur_pc      = 64'h8000_0000;
   logic [31:0] prev_inst   = 32'h13;
   logic        m_halt      = 1'b0;
   logic        m_err       = 1'b0;
   int          model_commits = 0;

   // Per-cycle expectations set by the driver.
   logic        chk_en       = 1'b0;
   logic        exp_imem_req = 1'b0;
   logic        exp_dmem_req = 1'b0;
   logic        exp_dmem_we  = 1'b0;
   logic        exp_commit   = 1'b0;
   logic        exp_rf_wen   = 1'b0;
   logic [31:0] exp_inst     = 32'h13;
   int          cur_k        = 0;

   // Observations collected by the compare process.
   int obs_commits  = 0;
   int obs_rfw      = 0;
   int obs_dreq     = 0;
   int obs_commit_k = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare the DUT against the model in the middle of every checked cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         check("pc",       pc_o,        cur_pc);
         check("imem_addr", imem_addr_o, cur_pc);
         check("inst",     inst_o,      exp_inst);
         check("imem_req", imem_req_o,  exp_imem_req);
         check("dmem_req", dmem_req_o,  exp_dmem_req);
         check("dmem_we",  dmem_we_o,   exp_dmem_we);
         check("commit",   commit_o,    exp_commit);
         check("rf_wen",   rf_wen_o,    exp_rf_wen);
         check("halt",     halt_o,      m_halt);
         check("err",      err_o,       m_err);
         if (commit_o) begin
            obs_commits++;
            obs_commit_k = cur_k;
         end
         if (rf_wen_o)   obs_rfw++;
         if (dmem_req_o) obs_dreq++;
      end
   end

   task automatic junk_dec();
      {dec_reg_wen_i, dec_mem_wen_i, dec_mem_ren_i, dec_pc_sel_i, dec_illegal_i, dec_ebreak_i} = 6'($urandom());
      alu_res_i = {$urandom(), $urandom()};
   endtask

   task automatic clear_inputs();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      dec_reg_wen_i = 1'b0; dec_mem_wen_i = 1'b0; dec_mem_ren_i = 1'b0;
      dec_pc_sel_i = 1'b0; dec_illegal_i = 1'b0; dec_ebreak_i = 1'b0;
      alu_res_i = '0;
   endtask

   // Assert reset (at any point of a cycle), check the immediate effect, release.
   task automatic do_reset();
      chk_en = 1'b0;
      rst    = 1'b1;
      clear_inputs();
      #1;
      check("rst_pc",       pc_o,       64'h8000_0000);
      check("rst_inst",     inst_o,     32'h0000_0013);
      check("rst_imem_req", imem_req_o, 1'b0);
      check("rst_dmem_req", dmem_req_o, 1'b0);
      check("rst_commit",   commit_o,   1'b0);
      check("rst_rf_wen",   rf_wen_o,   1'b0);
      check("rst_halt",     halt_o,     1'b0);
      check("rst_err",      err_o,      1'b0);
      @(posedge clk); #1;
      rst       = 1'b0;
      cur_pc    = 64'h8000_0000;
      prev_inst = 32'h13;
      m_halt    = 1'b0;
      m_err     = 1'b0;
      #1;
      check("release_imem_req", imem_req_o, 1'b1);
      chk_en = 1'b1;
   endtask

   // One instruction. Waits: ig grant cycles, ir rvalid after grant (0 = with
   // grant), dg data-grant wait, dr load data after grant. Stops at abort_k.
   task automatic run_instr(input int ig, input int ir, input int dg, input int dr,
                            input bit is_load, input bit is_store, input bit reg_wen,
                            input bit pc_sel, input logic [63:0] alu,
                            input logic [31:0] word, input int abort_k);
      int e, m0, w;
      bit mem, dcyc;
      mem = is_load || is_store;
      e   = ig + ir + 1;
      m0  = e + 1;
      if (!mem)          w = e + 1;
      else if (is_store) w = m0 + dg + 1;
      else               w = m0 + dg + dr + 1;
      for (int k = 0; k <= w; k++) begin
         if (k == abort_k) return;
         cur_k         = k;
         imem_gnt_i    = (k == ig);
         imem_rvalid_i = (k == ig + ir) || (k < ig && $urandom_range(0, 1) == 1);
         imem_rdata_i  = (k == ig + ir) ? word : $urandom();
         dcyc = (k == e) || (k == w) || (mem && k >= m0 && k <= m0 + dg);
         if (dcyc) begin
            dec_reg_wen_i = reg_wen;
            dec_mem_wen_i = is_store;
            dec_mem_ren_i = is_load;
            dec_pc_sel_i  = pc_sel;
            dec_illegal_i = 1'b0;
            dec_ebreak_i  = 1'b0;
            alu_res_i     = alu;
         end else begin
            junk_dec();
         end
         dmem_gnt_i    = mem && (k == m0 + dg);
         dmem_rvalid_i = (is_load && k == m0 + dg + dr) || (k <= e && $urandom_range(0, 1) == 1);
         exp_imem_req  = (k <= ig);
         exp_dmem_req  = mem && k >= m0 && k <= m0 + dg;
         exp_dmem_we   = exp_dmem_req && is_store;
         exp_commit    = (k == w);
         exp_rf_wen    = (k == w) && reg_wen;
         exp_inst      = (k >= e) ? word : prev_inst;
         @(posedge clk); #1;
      end
      prev_inst = word;
      cur_pc    = pc_sel ? (alu & ~64'h1) : (cur_pc + 64'd4);
      model_commits++;
   endtask

   // Zero-wait fetch of a trapping instruction, then hammer the halted core.
   task automatic run_trap(input bit ill, input bit ebk, input logic [31:0] word);
      int base_c, base_r;
      base_c = obs_commits;
      base_r = obs_rfw;
      cur_k = 0;
      imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = word;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      junk_dec();
      exp_imem_req = 1'b1; exp_dmem_req = 1'b0; exp_dmem_we = 1'b0;
      exp_commit = 1'b0; exp_rf_wen = 1'b0; exp_inst = prev_inst;
      @(posedge clk); #1;
      cur_k = 1;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
      dec_illegal_i = ill; dec_ebreak_i = ebk;
      dec_reg_wen_i = 1'b1; dec_mem_ren_i = 1'b1; dec_mem_wen_i = 1'b0;
      dec_pc_sel_i = 1'b1; alu_res_i = {$urandom(), $urandom()};
      exp_imem_req = 1'b0; exp_inst = word;
      @(posedge clk); #1;
      m_err  = ill;
      m_halt = !ill && ebk;
      for (int k = 2; k < 14; k++) begin
         cur_k = k;
         imem_gnt_i    = 1'($urandom());
         imem_rvalid_i = 1'($urandom());
         imem_rdata_i  = $urandom();
         dmem_gnt_i    = 1'($urandom());
         dmem_rvalid_i = 1'($urandom());
         junk_dec();
         @(posedge clk); #1;
      end
      check("trap_commits", 64'(obs_commits - base_c), 64'd0);
      check("trap_rf_wen",  64'(obs_rfw - base_r),     64'd0);
   endtask

   initial begin
      int bc, br, bd;
      int kind, ig, ir, dg, dr;
      bit pc_sel;
      clear_inputs();
      @(posedge clk); #1;
      do_reset();

      // addi x1,x0,5: zero-wait, commits on its 3rd cycle.
      bc = obs_commits; br = obs_rfw;
      run_instr(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 32'h0050_0093, -1);
      check("addi_commit_cycle", 64'(obs_commit_k), 64'd2);
      check("addi_rf_pulses",    64'(obs_rfw - br),  64'd1);
      check("addi_pc",           pc_o,               64'h8000_0004);

      // jal: target with bit 0 set is cleared.
      run_instr(1, 2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0101, 32'h0fc0_00ef, -1);
      check("jal_pc",         pc_o,        64'h8000_0100);
      check("jal_fetch_addr", imem_addr_o, 64'h8000_0100);

      // ld: grant after 2 waits, data 3 cycles after grant.
      br = obs_rfw; bd = obs_dreq;
      run_instr(0, 0, 2, 3, 1'b1, 1'b0, 1'b1, 1'b0, 64'h8000_1000, 32'h0000_b083, -1);
      check("ld_dreq_cycles",   64'(obs_dreq - bd),     64'd3);
      check("ld_wb_after_exec", 64'(obs_commit_k - 1),  64'd7);
      check("ld_rf_pulses",     64'(obs_rfw - br),      64'd1);

      // sd: store strobe, no register write.
      bc = obs_commits; br = obs_rfw;
      run_instr(0, 1, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_1008, 32'h0010_b423, -1);
      check("sd_commits",   64'(obs_commits - bc), 64'd1);
      check("sd_rf_pulses", 64'(obs_rfw - br),     64'd0);

      // PC wrap-around.
      run_instr(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 32'h0000_006f, -1);
      check("wrap_top_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
      run_instr(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 32'h0000_0013, -1);
      check("wrap_zero_pc", pc_o, 64'h0);

      // Randomized instruction stream.
      for (int i = 0; i < 60; i++) begin
         kind   = $urandom_range(0, 3);
         ig     = $urandom_range(0, 3);
         ir     = $urandom_range(0, 3);
         dg     = $urandom_range(0, 3);
         dr     = $urandom_range(0, 3);
         pc_sel = (kind == 1) || ($urandom_range(0, 3) == 0);
         run_instr(ig, ir, dg, dr, kind == 2, kind == 3, 1'($urandom()), pc_sel,
                   {$urandom(), $urandom()}, $urandom(), -1);
      end

      // Reset while a load waits for its data (cycle 4 is in MWAIT).
      run_instr(0, 0, 0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 64'h8000_2000, 32'h0001_3103, 4);
      do_reset();
      run_instr(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 32'h0050_0093, -1);
      check("post_rst_pc", pc_o, 64'h8000_0004);

      // Illegal (with ebreak also set) traps to err only; ebreak alone halts.
      run_trap(1'b1, 1'b1, 32'hFFFF_FFFF);
      check("illegal_err",  err_o,  1'b1);
      check("illegal_halt", halt_o, 1'b0);
      do_reset();
      run_trap(1'b0, 1'b1, 32'h0010_0073);
      check("ebreak_halt", halt_o, 1'b1);
      check("ebreak_err",  err_o,  1'b0);
      do_reset();

      // Fetch grant withheld: 255 waiting cycles, then error and request dropped.
      for (int k = 0; k <= 255; k++) begin
         cur_k         = k;
         imem_gnt_i    = 1'b0;
         imem_rvalid_i = 1'($urandom());
         imem_rdata_i  = $urandom();
         dmem_gnt_i    = 1'b0;
         dmem_rvalid_i = 1'($urandom());
         junk_dec();
         exp_imem_req = (k < 255);
         exp_dmem_req = 1'b0; exp_dmem_we = 1'b0;
         exp_commit = 1'b0; exp_rf_wen = 1'b0; exp_inst = prev_inst;
         m_err = (k == 255);
         if (k == 255) begin
            #2;
            check("tmo_err",      err_o,      1'b1);
            check("tmo_imem_req", imem_req_o, 1'b0);
         end
         @(posedge clk); #1;
      end

      check("total_commits", 64'(obs_commits), 64'(model_commits));
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

endmodule
